simt_branch_ctrl: RTL and testbench

Branch-divergence controller for the SIMT core. It sits directly upstream of the SIMT reconvergence stack. It resolves per-thread branch outcomes from execute and classifies each branch as uniform or divergent. It drives push/pop requests and their operands into the stack, detects reconvergence at the fetch PC, and issues PC redirects to fetch.

---
 rtl/cpu_types_pkg.sv | 17 +
 rtl/simt_branch_classify.sv | 22 ++
 rtl/simt_branch_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_simt_branch_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared SIMT core types: machine word, branch controller states, default warp width.
package cpu_types_pkg;

    localparam int THREADS_DEFAULT = 4;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH,
        ST_POP,
        ST_RESUME,
        ST_REDIR,
        ST_ERROR
    } branch_state_t;

endpackage

// File: rtl/simt_branch_classify.sv
// Combinational branch classifier: masks per-lane outcomes with the active lanes
// and flags uniform taken / uniform not-taken branches.
module simt_branch_classify
    import cpu_types_pkg::*;
#(
    parameter int THREADS = THREADS_DEFAULT
) (
    input  logic [THREADS-1:0] br_taken,
    input  logic [THREADS-1:0] cur_mask,
    output logic [THREADS-1:0] t,
    output logic               is_uniform_taken,
    output logic               is_uniform_not_taken
);

    // An empty active mask counts as not-taken so it can never trigger a redirect.
    always_comb begin
        t                    = br_taken & cur_mask;
        is_uniform_not_taken = (t == '0);
        is_uniform_taken     = !is_uniform_not_taken && (t == cur_mask);
    end

endmodule

// File: rtl/simt_branch_ctrl.sv
// SIMT branch-divergence controller feeding the reconvergence stack and fetch.
// Optional performance counters are built when SIMT_BRANCH_PERF_EN is defined.
module simt_branch_ctrl
    import cpu_types_pkg::*;
#(
    parameter int THREADS     = THREADS_DEFAULT,
    parameter int STACK_DEPTH = 16
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               br_valid,
    output logic               br_ready,
    input  word_t              br_target,
    input  word_t              br_sync,
    input  logic [THREADS-1:0] br_taken,
    input  logic               fetch_valid,
    input  word_t              fetch_pc,
    input  logic [THREADS-1:0] cur_mask,
    input  word_t              cur_sync,
    input  word_t              cur_addr,
    output logic               push_en,
    output logic [THREADS-1:0] new_mask,
    output word_t              new_sync,
    output word_t              new_addr,
    output logic               pop_en,
    output logic               redirect_en,
    output word_t              redirect_pc,
    output logic [THREADS-1:0] active_mask,
    output logic               div_err
`ifdef SIMT_BRANCH_PERF_EN
    ,
    output word_t              perf_div_cnt,
    output word_t              perf_uni_cnt,
    output word_t              perf_reconv_cnt
`endif
);

    localparam int DW = $clog2(STACK_DEPTH) + 1;
    // A divergent push adds two entries; beyond this depth it would overrun the stack.
    localparam logic [DW-1:0] PUSH_LIMIT = DW'(STACK_DEPTH - 4);

    branch_state_t      state;
    branch_state_t      state_nxt;
    logic [DW-1:0]      depth;
    logic [THREADS-1:0] t_c;
    logic [THREADS-1:0] t_q;
    logic [THREADS-1:0] mask_q;
    logic               mask_hold;
    logic               uni_taken;
    logic               uni_not_taken;
    logic               hit;
    logic               accept;
    word_t              pc_q;

    simt_branch_classify #(
        .THREADS (THREADS)
    ) u_classify (
        .br_taken             (br_taken),
        .cur_mask             (cur_mask),
        .t                    (t_c),
        .is_uniform_taken     (uni_taken),
        .is_uniform_not_taken (uni_not_taken)
    );

    always_comb begin
        hit      = (state == ST_IDLE) && fetch_valid && (fetch_pc == cur_sync) && (depth != '0);
        br_ready = (state == ST_IDLE) && !hit;
        accept   = br_valid && br_ready;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (hit) begin
                    state_nxt = ST_POP;
                end else if (accept && !uni_not_taken) begin
                    if (uni_taken)
                        state_nxt = ST_REDIR;
                    else if (depth > PUSH_LIMIT)
                        state_nxt = ST_ERROR;
                    else
                        state_nxt = ST_PUSH;
                end
            end
            ST_PUSH:   state_nxt = ST_REDIR;
            ST_POP:    state_nxt = ST_RESUME;
            ST_RESUME: state_nxt = ST_IDLE;
            ST_REDIR:  state_nxt = ST_IDLE;
            ST_ERROR:  state_nxt = ST_ERROR;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are flopped from the next state so each lands exactly one cycle after its cause.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= ST_IDLE;
            depth       <= '0;
            push_en     <= 1'b0;
            pop_en      <= 1'b0;
            redirect_en <= 1'b0;
            div_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            push_en     <= (state_nxt == ST_PUSH);
            pop_en      <= (state_nxt == ST_POP);
            redirect_en <= (state_nxt == ST_REDIR) || (state_nxt == ST_RESUME);
            div_err     <= div_err || (state_nxt == ST_ERROR);
            if (state == ST_PUSH)
                depth <= depth + DW'(2);
            else if (state == ST_POP)
                depth <= depth - DW'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            t_q       <= '0;
            new_mask  <= '0;
            new_sync  <= '0;
            new_addr  <= '0;
            pc_q      <= '0;
            mask_q    <= '1;
            mask_hold <= 1'b0;
        end else begin
            if (accept)
                t_q <= t_c;
            if (accept && (state_nxt == ST_PUSH)) begin
                new_mask <= cur_mask & ~t_c;
                new_sync <= br_sync;
                new_addr <= br_target;
            end
            if (accept && !uni_not_taken)
                pc_q <= br_target;
            else if (state == ST_RESUME)
                pc_q <= cur_addr;
            // After a push the taken lanes keep issuing until the next pop restores the stack top.
            case (state)
                ST_IDLE: begin
                    if (!mask_hold)
                        mask_q <= cur_mask;
                end
                ST_PUSH: begin
                    mask_q    <= t_q;
                    mask_hold <= 1'b1;
                end
                ST_RESUME: begin
                    mask_q    <= cur_mask;
                    mask_hold <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // The popped-to entry only becomes visible on the stack outputs during RESUME.
    assign redirect_pc = (state == ST_RESUME) ? cur_addr : pc_q;
    assign active_mask = (state == ST_RESUME) ? cur_mask : mask_q;

`ifdef SIMT_BRANCH_PERF_EN
    function automatic word_t sat_inc(input word_t v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_div_cnt    <= '0;
            perf_uni_cnt    <= '0;
            perf_reconv_cnt <= '0;
        end else begin
            if (accept && !hit && !uni_taken && !uni_not_taken)
                perf_div_cnt <= sat_inc(perf_div_cnt);
            if (accept && (uni_taken || uni_not_taken))
                perf_uni_cnt <= sat_inc(perf_uni_cnt);
            if (state == ST_POP)
                perf_reconv_cnt <= sat_inc(perf_reconv_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_simt_branch_ctrl.sv
// Self-checking bench for simt_branch_ctrl: directed literal cases plus random
// traffic compared every cycle against a queue-based behavioural model.
module tb_simt_branch_ctrl;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_ready;
    logic [31:0] br_target = '0;
    logic [31:0] br_sync = '0;
    logic [3:0]  br_taken = '0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic [3:0]  cur_mask = 4'hF;
    logic [31:0] cur_sync = '0;
    logic [31:0] cur_addr = '0;
    logic        push_en;
    logic [3:0]  new_mask;
    logic [31:0] new_sync;
    logic [31:0] new_addr;
    logic        pop_en;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [3:0]  active_mask;
    logic        div_err;

    int checks = 0;
    int errors = 0;

    simt_branch_ctrl #(.THREADS(4), .STACK_DEPTH(16)) dut (
        .CLK(CLK), .nRST(nRST),
        .br_valid(br_valid), .br_ready(br_ready), .br_target(br_target), .br_sync(br_sync),
        .br_taken(br_taken), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .cur_mask(cur_mask), .cur_sync(cur_sync), .cur_addr(cur_addr),
        .push_en(push_en), .new_mask(new_mask), .new_sync(new_sync), .new_addr(new_addr),
        .pop_en(pop_en), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .active_mask(active_mask), .div_err(div_err)
    );

    always #5 CLK = ~CLK;

    // One expected output cycle of the controller
    typedef struct {
        bit          push;
        bit          pop;
        bit          redir;
        bit          from_top;
        bit          mchk;
        logic [31:0] pc;
        logic [3:0]  mask;
        logic [3:0]  nmask;
        logic [31:0] nsync;
        logic [31:0] naddr;
    } slot_t;

    slot_t q[$];
    slot_t cur;
    bit    busy = 0;
    bit    m_err = 0;
    int    m_depth = 0;

    function automatic slot_t idle_slot();
        slot_t s;
        s.push = 0; s.pop = 0; s.redir = 0; s.from_top = 0; s.mchk = 0;
        s.pc = '0; s.mask = '0; s.nmask = '0; s.nsync = '0; s.naddr = '0;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: when idle, a decision schedules the future output cycles it causes.
    initial begin
        slot_t       s;
        logic [3:0]  t;
        cur = idle_slot();
        forever begin
            @(posedge CLK or negedge nRST);
            if (!nRST) begin
                q.delete();
                cur = idle_slot();
                busy = 0; m_err = 0; m_depth = 0;
            end else begin
                if (!m_err && !busy) begin
                    t = br_taken & cur_mask;
                    if (fetch_valid && fetch_pc == cur_sync && m_depth != 0) begin
                        m_depth = m_depth - 1;
                        s = idle_slot(); s.pop = 1; q.push_back(s);
                        s = idle_slot(); s.redir = 1; s.from_top = 1; s.mchk = 1; q.push_back(s);
                    end else if (br_valid && t != 4'h0) begin
                        if (t == cur_mask) begin
                            s = idle_slot(); s.redir = 1; s.pc = br_target; q.push_back(s);
                        end else if (m_depth + 2 > 16 - 2) begin
                            m_err = 1;
                        end else begin
                            m_depth = m_depth + 2;
                            s = idle_slot(); s.push = 1; s.nmask = cur_mask & ~t;
                            s.nsync = br_sync; s.naddr = br_target; q.push_back(s);
                            s = idle_slot(); s.redir = 1; s.pc = br_target; s.mchk = 1; s.mask = t;
                            q.push_back(s);
                        end
                    end
                end
                if (q.size() != 0) begin
                    cur = q.pop_front();
                    busy = 1;
                end else begin
                    cur = idle_slot();
                    busy = 0;
                end
            end
        end
    end

    // Compare process, mid-cycle on every out-of-reset cycle
    initial begin
        bit exp_ready;
        forever begin
            @(negedge CLK);
            if (nRST) begin
                exp_ready = !m_err && !busy && !(fetch_valid && fetch_pc == cur_sync && m_depth != 0);
                check("br_ready", 32'(br_ready), 32'(exp_ready));
                check("push_en", 32'(push_en), 32'(cur.push));
                check("pop_en", 32'(pop_en), 32'(cur.pop));
                check("redirect_en", 32'(redirect_en), 32'(cur.redir));
                check("div_err", 32'(div_err), 32'(m_err));
                if (cur.push) begin
                    check("new_mask", 32'(new_mask), 32'(cur.nmask));
                    check("new_sync", new_sync, cur.nsync);
                    check("new_addr", new_addr, cur.naddr);
                end
                if (cur.redir)
                    check("redirect_pc", redirect_pc, cur.from_top ? cur_addr : cur.pc);
                if (cur.mchk)
                    check("active_mask", 32'(active_mask), 32'(cur.from_top ? cur_mask : cur.mask));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_vals();
        check("rst_push_en", 32'(push_en), 0);
        check("rst_pop_en", 32'(pop_en), 0);
        check("rst_redirect_en", 32'(redirect_en), 0);
        check("rst_br_ready", 32'(br_ready), 1);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_new_mask", 32'(new_mask), 0);
        check("rst_new_sync", new_sync, 0);
        check("rst_new_addr", new_addr, 0);
        check("rst_active_mask", 32'(active_mask), 32'hF);
        check("rst_div_err", 32'(div_err), 0);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        @(negedge CLK);
        check_reset_vals();
        tick();
        nRST = 1'b1;
    endtask

    task automatic wait_ready();
        bit got = 0;
        for (int n = 0; n < 12 && !got; n++) begin
            @(negedge CLK);
            if (br_ready) got = 1;
        end
        check("wait_ready", 32'(got), 1);
    endtask

    initial begin
        tick();
        do_reset();

        // Uniform taken
        cur_mask = 4'hF; br_taken = 4'hF; br_target = 32'h100; br_sync = 32'h180; br_valid = 1;
        @(negedge CLK); check("t1_ready", 32'(br_ready), 1);
        tick(); br_valid = 0;
        @(negedge CLK);
        check("t1_redir", 32'(redirect_en), 1);
        check("t1_pc", redirect_pc, 32'h100);
        check("t1_nopush", 32'(push_en), 0);
        tick();
        @(negedge CLK); check("t1_ready_back", 32'(br_ready), 1);

        // Divergent
        tick();
        br_taken = 4'h5; br_target = 32'h200; br_sync = 32'h300; br_valid = 1;
        @(negedge CLK); check("t2_ready", 32'(br_ready), 1);
        tick(); br_valid = 0;
        @(negedge CLK);
        check("t2_push", 32'(push_en), 1);
        check("t2_new_mask", 32'(new_mask), 32'hA);
        check("t2_new_sync", new_sync, 32'h300);
        check("t2_new_addr", new_addr, 32'h200);
        tick();
        @(negedge CLK);
        check("t2_redir", 32'(redirect_en), 1);
        check("t2_pc", redirect_pc, 32'h200);
        check("t2_active", 32'(active_mask), 32'h5);
        tick();
        cur_mask = 4'hA; cur_sync = 32'h300; cur_addr = 32'h280;
        @(negedge CLK); check("t2_ready_back", 32'(br_ready), 1);

        // Reconvergence at depth 2
        tick();
        fetch_valid = 1; fetch_pc = 32'h300;
        @(negedge CLK); check("t3_hit_ready", 32'(br_ready), 0);
        tick(); fetch_valid = 0;
        @(negedge CLK); check("t3_pop", 32'(pop_en), 1);
        tick(); cur_addr = 32'h440; cur_mask = 4'hF; cur_sync = 32'h900;
        @(negedge CLK);
        check("t3_redir", 32'(redirect_en), 1);
        check("t3_pc", redirect_pc, 32'h440);
        check("t3_active", 32'(active_mask), 32'hF);
        check("t3_nopop", 32'(pop_en), 0);

        // Branch and hit together at depth 1: pop first, branch afterwards
        tick();
        fetch_valid = 1; fetch_pc = 32'h900; br_valid = 1; br_taken = 4'hF; br_target = 32'h500;
        @(negedge CLK); check("t4_held", 32'(br_ready), 0);
        tick(); fetch_valid = 0;
        @(negedge CLK);
        check("t4_pop", 32'(pop_en), 1);
        check("t4_busy", 32'(br_ready), 0);
        tick(); cur_addr = 32'h600;
        @(negedge CLK);
        check("t4_resume", 32'(redirect_en), 1);
        check("t4_resume_pc", redirect_pc, 32'h600);
        tick();
        @(negedge CLK); check("t4_accept", 32'(br_ready), 1);
        tick(); br_valid = 0;
        @(negedge CLK);
        check("t4_redir", 32'(redirect_en), 1);
        check("t4_pc", redirect_pc, 32'h500);

        // Hit at depth 0 is ignored; not-taken branch does nothing
        tick();
        fetch_valid = 1; fetch_pc = cur_sync; br_valid = 1; br_taken = 4'h0;
        @(negedge CLK); check("t5_ready", 32'(br_ready), 1);
        tick(); br_valid = 0;
        @(negedge CLK);
        check("t5_nopop", 32'(pop_en), 0);
        check("t5_nopush", 32'(push_en), 0);
        check("t5_noredir", 32'(redirect_en), 0);
        check("t5_ready_after", 32'(br_ready), 1);
        tick(); fetch_valid = 0;

        // Random traffic with occasional mid-operation resets
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 149) do_reset();
            br_valid    = 1'($urandom_range(0, 1));
            br_taken    = 4'($urandom);
            cur_mask    = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            br_target   = $urandom;
            br_sync     = $urandom;
            cur_addr    = $urandom;
            cur_sync    = 32'($urandom_range(0, 3)) << 4;
            fetch_valid = ($urandom_range(0, 2) == 0);
            fetch_pc    = ($urandom_range(0, 1) == 1) ? cur_sync : $urandom;
            tick();
        end

        // Overflow: eight divergent branches from depth 0
        br_valid = 0; fetch_valid = 0;
        do_reset();
        cur_mask = 4'hF; br_taken = 4'h3; br_target = 32'h700; br_sync = 32'h800;
        for (int k = 0; k < 8; k++) begin
            br_valid = 1;
            wait_ready();
            tick();
            br_valid = 0;
        end
        @(negedge CLK);
        check("err_div_err", 32'(div_err), 1);
        check("err_ready", 32'(br_ready), 0);
        check("err_nopush", 32'(push_en), 0);
        br_valid = 1;
        repeat (3) tick();
        @(negedge CLK);
        check("err_sticky", 32'(div_err), 1);
        check("err_still_blocked", 32'(br_ready), 0);
        tick(); br_valid = 0;
        do_reset();
        @(negedge CLK);
        check("post_err_div_err", 32'(div_err), 0);
        check("post_err_ready", 32'(br_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
